// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8 - 8-way round-robin arbiter with registered grant/hold/release.
//
// An idle arbiter samples req and grants the first requester found scanning
// circularly upward from one past the previous winner (last). The grant is
// held until the owner drops its request or pulses rel. At least one idle
// cycle always separates two grants. Requests that arrive while a grant is
// active neither preempt it nor get latched.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a hold counter revokes a grant after exactly MAX_HOLD
//   visible cycles and pulses timeout for one cycle. When undefined there is
//   no counter logic, timeout is constant 0 and a grant may be held forever.
//
// Ports:
//   clk       in   1    system clock, rising edge
//   rst       in   1    asynchronous active-high reset
//   req       in   N    request vector, bit i = requester i
//   rel       in   1    release strobe from the owner (ignored when idle)
//   gnt       out  N    one-hot grant, registered
//   gnt_id    out  IDW  binary index of the owner, registered (0 when idle)
//   gnt_valid out  1    high while a grant is active (OR of gnt)
//   timeout   out  1    one-cycle pulse when a grant is forcibly revoked
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           rel,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Circular priority scan: returns {found, index} of the first set bit of
    // r starting at ptr+1 and wrapping. Iterating from the farthest offset to
    // the nearest lets the nearest hit overwrite earlier ones. Offset 8
    // truncates to 0, so ptr itself is considered last.
    function automatic logic [3:0] pick_winner(input logic [7:0] r,
                                               input logic [2:0] ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = ptr + 3'(i);
            res = r[idx] ? {1'b1, idx} : res;
        end
        return res;
    endfunction

    state_t           state_q,     state_d;
    logic [2:0]       last_q,      last_d;
    logic [N-1:0]     gnt_q,       gnt_d;
    logic [IDW-1:0]   gnt_id_q,    gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q,   timeout_d;

    logic [3:0]       win_s;
    logic             release_s;
    logic             expire_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0]       hold_cnt_q,  hold_cnt_d;
`else
    logic             unused_max_hold_s;
    assign unused_max_hold_s = ^8'(MAX_HOLD);
`endif

    assign win_s     = pick_winner(req, last_q);
    // Release is only meaningful in GRANT; rel and a dropped request together
    // still amount to a single release.
    assign release_s = rel | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
    assign expire_s  = (hold_cnt_q == HOLD_LAST);
`else
    assign expire_s  = 1'b0;
`endif

    // Next-state and next-output computation for the grant FSM.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_s[3]) begin
                    state_d     = ST_GRANT;
                    last_d      = win_s[2:0];
                    gnt_d       = N'(8'd1 << win_s[2:0]);
                    gnt_id_d    = IDW'(win_s[2:0]);
                    gnt_valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = 8'd0;
`endif
                end else begin
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // Normal release wins over a coincident timeout.
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end else if (expire_s) begin
                    // Forced revoke; last keeps the owner so it ranks lowest.
                    state_d     = ST_IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d  = hold_cnt_q + 8'd1;
`endif
                    state_d     = ST_GRANT;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 3'd7;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- The resource is typically a bus or a shared encoder/datapath slot.
- Built around the 8:3 priority-encoding function, with a rotating priority pointer and a registered grant/hold/release handshake.
- Sits between requesting agents and the shared resource; the resource mux uses gnt_id as its select.

Parameters:
- N, 8: number of requesters (fixed at 8 in this revision)
- IDW, 3: width of gnt_id, equal to log2(N)
- MAX_HOLD, 16: maximum cycles a grant may be held; used only with ARB_TIMEOUT_EN; legal range 2..255

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N  request vector; bit i high = requester i wants the resource
- rel  input  1  release strobe from the current owner; ignored when no grant is active
- gnt  output  N  one-hot grant vector, registered
- gnt_id  output  IDW  binary index of the granted requester, registered
- gnt_valid  output  1  high while any grant is active; equals OR of gnt
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

Behaviour:
- Reset (asynchronous, any time, including mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - State=IDLE, priority pointer last=7, so requester 0 has top priority after reset.
  - Hold counter cleared.
- State machine has 2 states, IDLE and GRANT.
- IDLE:
  - req is sampled at the clock edge.
  - If req!=0, the winner is the first set bit scanning circularly from index last+1 mod 8 upward.
  - Next edge: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, last=winner, state=GRANT.
  - Latency is 1 cycle from sampled req to visible gnt.
  - If req==0, stay in IDLE with all outputs 0.
- GRANT:
  - The grant holds while req[gnt_id]=1 and rel=0.
  - Release condition: rel=1, or req[gnt_id]=0, sampled at the edge. Next edge: gnt=0, gnt_valid=0, gnt_id=0, state=IDLE.
  - There is one mandatory dead cycle between consecutive grants, so the earliest new grant is 2 edges after the release edge.
  - Requests from other requesters during GRANT do not preempt and are not latched; they are only evaluated in IDLE.
- Simultaneous events:
  - rel together with req[gnt_id]=0 is a single release.
  - rel together with the owner re-requesting still releases. The owner then competes in IDLE with lowest priority, because last=owner.
- Fairness: any continuously asserted requester is granted within 8 grant cycles.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_id is 0 whenever gnt_valid=0.
  - The priority pointer wraps 7->0.

Optional Feature:
- Macro ARB_TIMEOUT_EN, defined:
  - An 8-bit hold counter clears on grant entry and increments each cycle in GRANT.
  - When the counter reaches MAX_HOLD-1 with no normal release, the next edge forces release: gnt=0 and state=IDLE, and timeout=1 for exactly that one cycle.
  - The grant is therefore visible for exactly MAX_HOLD cycles.
  - The pointer still equals the revoked owner, so that owner has lowest priority next.
  - If a normal release coincides with the timeout point, it is treated as a normal release and timeout stays 0.
- Macro undefined:
  - No counter logic is present, timeout is tied to 0, and a grant may be held indefinitely.

Test Plan:
- Reset, then hold req=8'b00000000 for 5 cycles -> gnt=0, gnt_id=0, gnt_valid=0 throughout.
- After reset, req=8'b00000110 -> one edge later gnt=8'b00000010, gnt_id=1. Pulse rel -> gnt=0 next edge. Two edges after the release, gnt=8'b00000100, gnt_id=2 (rotation).
- req=8'b11111111 held, owner pulses rel each time it is granted -> grant order 0,1,2,...,7,0 with one idle cycle between each grant.
- Owner 5 granted, then drops req[5] while req=8'b10000001 -> gnt=0 next edge, then gnt_id=7 (first after 5 circularly), not 0.
- Assert rst asynchronously mid-grant (gnt_id=3) -> gnt, gnt_valid and gnt_id go 0 immediately without a clock edge. After release with req=8'b00001001, gnt_id=0.
- ARB_TIMEOUT_EN defined, MAX_HOLD=4, req=8'b00000001 held with no rel:
  - gnt is high for exactly 4 cycles, then timeout=1 for 1 cycle with gnt=0.
  - Requester 0 is then re-granted 1 cycle later.
  - With the macro undefined, the same stimulus keeps gnt=8'b00000001 indefinitely and timeout=0.
